// File: rtl/exponent_align_pipe_if.sv
// Operand/result bundle for exponent_align_pipe: input handshake and operands,
// output handshake and aligned results.
interface exponent_align_pipe_if #(
  parameter int unsigned ExponentSize = 8,
  parameter int unsigned MantissaSize = 24
);
  localparam int unsigned MaxShift   = MantissaSize + 3;
  localparam int unsigned ShiftWidth = $clog2(MaxShift + 1);

  logic                    InValid;
  logic                    InReady;
  logic [ExponentSize-1:0] Exponent1;
  logic [ExponentSize-1:0] Exponent2;
  logic [MantissaSize-1:0] Mantissa1;
  logic [MantissaSize-1:0] Mantissa2;
  logic                    OutValid;
  logic                    OutReady;
  logic [ExponentSize-1:0] LargeExponent;
  logic [MantissaSize-1:0] LargeMantissa;
  logic [MantissaSize+2:0] AlignedMantissa;
  logic [ShiftWidth-1:0]   Difference;
  logic                    Sign;
  logic                    ZeroFlag;
  logic                    Saturated;

  modport master (
    output InValid, Exponent1, Exponent2, Mantissa1, Mantissa2, OutReady,
    input  InReady, OutValid, LargeExponent, LargeMantissa, AlignedMantissa,
           Difference, Sign, ZeroFlag, Saturated
  );

  modport slave (
    input  InValid, Exponent1, Exponent2, Mantissa1, Mantissa2, OutReady,
    output InReady, OutValid, LargeExponent, LargeMantissa, AlignedMantissa,
           Difference, Sign, ZeroFlag, Saturated
  );
endinterface

// File: rtl/exponent_align_pipe.sv
// Two-stage exponent compare/swap and mantissa right-align for the FP adder.
// Define ALIGN_STICKY_EN to fold shifted-out bits into the sticky bit.
module exponent_align_pipe #(
  parameter int unsigned ExponentSize = 8,
  parameter int unsigned MantissaSize = 24
) (
  input logic                  Clk,
  input logic                  Reset,
  exponent_align_pipe_if.slave bus
);
  localparam int unsigned MaxShift   = MantissaSize + 3;
  localparam int unsigned ShiftWidth = $clog2(MaxShift + 1);
  localparam int unsigned ExtWidth   = MantissaSize + 3;

  logic v1Q, v2Q;
  logic ready1, ready2;

  // Stage 1 registers
  logic [ExponentSize-1:0] largeExpQ;
  logic [MantissaSize-1:0] largeMantQ;
  logic [MantissaSize-1:0] smallMantQ;
  logic [ShiftWidth-1:0]   diffQ;
  logic                    signQ, zeroQ, satQ;

  // Stage 2 (output) registers
  logic [ExponentSize-1:0] outExpQ;
  logic [MantissaSize-1:0] outMantQ;
  logic [ExtWidth-1:0]     outAlignedQ;
  logic [ShiftWidth-1:0]   outDiffQ;
  logic                    outSignQ, outZeroQ, outSatQ;

  logic                    swap;
  logic [ExponentSize-1:0] rawDiff;
  logic                    rawSat;
  logic [ShiftWidth-1:0]   diffD;

  logic [ExtWidth-1:0]     ext;
  logic [ExtWidth-1:0]     shifted;
  logic [ExtWidth-1:0]     alignedD;

  assign ready2      = !v2Q || bus.OutReady;
  assign ready1      = !v1Q || ready2;
  assign bus.InReady = ready1;
  assign bus.OutValid = v2Q;

  always_comb begin
    swap    = bus.Exponent2 > bus.Exponent1;
    rawDiff = swap ? (bus.Exponent2 - bus.Exponent1) : (bus.Exponent1 - bus.Exponent2);
    rawSat  = 32'(rawDiff) >= MaxShift;
    diffD   = rawSat ? ShiftWidth'(MaxShift) : ShiftWidth'(rawDiff);
  end

`ifdef ALIGN_STICKY_EN
  logic [ExtWidth-1:0] lostMask;
`endif

  always_comb begin
    ext      = {smallMantQ, 3'b000};
    shifted  = ext >> diffQ;
    alignedD = satQ ? '0 : {shifted[ExtWidth-1:1], 1'b0};
`ifdef ALIGN_STICKY_EN
    // Shift by the full width yields an all-ones mask, i.e. OR of the whole mantissa.
    lostMask    = ~({ExtWidth{1'b1}} << diffQ);
    alignedD[0] = shifted[0] | (|(ext & lostMask));
`else
    alignedD[0] = shifted[0];
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1Q         <= 1'b0;
      v2Q         <= 1'b0;
      largeExpQ   <= '0;
      largeMantQ  <= '0;
      smallMantQ  <= '0;
      diffQ       <= '0;
      signQ       <= 1'b0;
      zeroQ       <= 1'b0;
      satQ        <= 1'b0;
      outExpQ     <= '0;
      outMantQ    <= '0;
      outAlignedQ <= '0;
      outDiffQ    <= '0;
      outSignQ    <= 1'b0;
      outZeroQ    <= 1'b0;
      outSatQ     <= 1'b0;
    end else begin
      if (ready1) begin
        v1Q <= bus.InValid;
        if (bus.InValid) begin
          largeExpQ  <= swap ? bus.Exponent2 : bus.Exponent1;
          largeMantQ <= swap ? bus.Mantissa2 : bus.Mantissa1;
          smallMantQ <= swap ? bus.Mantissa1 : bus.Mantissa2;
          diffQ      <= diffD;
          signQ      <= swap;
          zeroQ      <= bus.Exponent1 == bus.Exponent2;
          satQ       <= rawSat;
        end
      end
      if (ready2) begin
        v2Q <= v1Q;
        if (v1Q) begin
          outExpQ     <= largeExpQ;
          outMantQ    <= largeMantQ;
          outAlignedQ <= alignedD;
          outDiffQ    <= diffQ;
          outSignQ    <= signQ;
          outZeroQ    <= zeroQ;
          outSatQ     <= satQ;
        end
      end
    end
  end

  assign bus.LargeExponent   = outExpQ;
  assign bus.LargeMantissa   = outMantQ;
  assign bus.AlignedMantissa = outAlignedQ;
  assign bus.Difference      = outDiffQ;
  assign bus.Sign            = outSignQ;
  assign bus.ZeroFlag        = outZeroQ;
  assign bus.Saturated       = outSatQ;
endmodule
